// File: rtl/sdcard_dma_engine.sv
// SPI SD-card host with bidirectional block DMA and a CRC16-CCITT accumulator.
// Holds the sdcard_spi byte engine (mode 0, MSB first) and the register/DMA front end.

module sdcard_spi (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic [7:0] divider,
    output logic       finished,
    output logic [7:0] data_out,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso
);
    logic       active;
    logic       phase;
    logic [7:0] cnt;
    logic [7:0] shreg;
    logic [7:0] rx;
    logic [2:0] bit_cnt;

    // Each sclk half period lasts divider+1 clocks; miso is sampled as sclk rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            active   <= 1'b0;
            phase    <= 1'b0;
            cnt      <= 8'h00;
            shreg    <= 8'hFF;
            rx       <= 8'h00;
            bit_cnt  <= 3'd0;
            sclk     <= 1'b0;
            finished <= 1'b0;
            data_out <= 8'h00;
        end else begin
            finished <= 1'b0;
            if (!active) begin
                if (start) begin
                    active  <= 1'b1;
                    phase   <= 1'b0;
                    cnt     <= divider;
                    shreg   <= data_in;
                    bit_cnt <= 3'd0;
                end
            end else if (cnt != 8'h00) begin
                cnt <= cnt - 8'h01;
            end else begin
                cnt <= divider;
                if (!phase) begin
                    sclk  <= 1'b1;
                    rx    <= {rx[6:0], miso};
                    phase <= 1'b1;
                end else begin
                    sclk    <= 1'b0;
                    phase   <= 1'b0;
                    shreg   <= {shreg[6:0], 1'b1};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        active   <= 1'b0;
                        finished <= 1'b1;
                        data_out <= rx;
                    end
                end
            end
        end
    end

    assign mosi = shreg[7];
endmodule

module sdcard_dma_engine #(
    parameter int BLOCK_LEN = 512,
    parameter int AW        = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic          sclk,
    output logic          mosi,
    input  logic          miso,
    input  logic [2:0]    sram_a,
    input  logic [7:0]    sram_d_in,
    output logic [7:0]    sram_d_out,
    input  logic          sram_cs,
    input  logic          sram_oe,
    input  logic          sram_we,
    output logic          sram_wait,
    output logic [7:0]    dma_wr_data,
    output logic [AW-1:0] dma_wr_addr,
    output logic          dma_wr_strobe,
    output logic [AW-1:0] dma_rd_addr,
    input  logic [7:0]    dma_rd_data,
    output logic          dma_done
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SEND, S_WAIT, S_STORE} state_t;

    localparam logic [AW-1:0] LAST = AW'(BLOCK_LEN - 1);

    state_t        state;
    logic [7:0]    divider;
    logic [4:0]    bits;
    logic          avail;
    logic          dir;
    logic          abort;
    logic [7:0]    latch;
    logic [7:0]    tx_byte;
    logic [15:0]   crc;
    logic [AW-1:0] count;
    logic [11:0]   count_ext;
    logic          spi_start;
    logic          spi_finished;
    logic [7:0]    spi_data_out;
    logic          busy;
    logic          reg_wr;
    logic          unused_oe;

    assign reg_wr    = sram_cs & sram_we;
    assign busy      = (state != S_IDLE);
    assign count_ext = 12'(count);
    assign sram_wait = 1'b0;
    assign unused_oe = sram_oe;

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) begin
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        end
        return r;
    endfunction

    sdcard_spi u_spi (
        .clk      (clk),
        .rst      (rst),
        .start    (spi_start),
        .data_in  (tx_byte),
        .divider  (divider),
        .finished (spi_finished),
        .data_out (spi_data_out),
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (miso)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            divider       <= 8'h00;
            bits          <= 5'h00;
            avail         <= 1'b0;
            dir           <= 1'b0;
            abort         <= 1'b0;
            latch         <= 8'h00;
            tx_byte       <= 8'hFF;
            crc           <= 16'h0000;
            count         <= '0;
            spi_start     <= 1'b0;
            dma_wr_data   <= 8'h00;
            dma_wr_addr   <= '0;
            dma_wr_strobe <= 1'b0;
            dma_rd_addr   <= '0;
            dma_done      <= 1'b0;
        end else begin
            spi_start     <= 1'b0;
            dma_wr_strobe <= 1'b0;
            dma_done      <= 1'b0;
            if (reg_wr && sram_a == 3'd2) divider <= sram_d_in;
            if (reg_wr && sram_a == 3'd0) bits <= sram_d_in[4:0];

            case (state)
                S_IDLE: begin
                    if (reg_wr && sram_a == 3'd0 && sram_d_in[6]) begin
                        dir   <= sram_d_in[5];
                        count <= '0;
                        crc   <= 16'h0000;
                        abort <= 1'b0;
                        if (sram_d_in[5]) begin
                            state       <= S_FETCH;
                            dma_rd_addr <= '0;
                        end else begin
                            state <= S_SEND;
                        end
                    end
                    if (reg_wr && sram_a == 3'd1) begin
                        spi_start <= 1'b1;
                        tx_byte   <= sram_d_in;
                    end
                    // A byte finishing in the same cycle as a new reg1 write keeps avail set.
                    if (spi_finished) begin
                        avail <= 1'b1;
                        latch <= spi_data_out;
                    end else if (reg_wr && sram_a == 3'd1) begin
                        avail <= 1'b0;
                    end else if (reg_wr && sram_a == 3'd0) begin
                        avail <= sram_d_in[7];
                    end
                end
                S_FETCH: state <= S_SEND;
                S_SEND: begin
                    tx_byte   <= dir ? dma_rd_data : 8'hFF;
                    spi_start <= 1'b1;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (spi_finished) begin
                        latch <= spi_data_out;
                        avail <= 1'b1;
                        state <= S_STORE;
                    end
                end
                S_STORE: begin
                    avail <= 1'b0;
                    crc   <= crc_byte(crc, dir ? tx_byte : latch);
                    if (!dir) begin
                        dma_wr_strobe <= 1'b1;
                        dma_wr_addr   <= count;
                        dma_wr_data   <= latch;
                    end
                    if (count == LAST || abort) begin
                        state    <= S_IDLE;
                        dma_done <= 1'b1;
                        abort    <= 1'b0;
                    end else begin
                        count <= count + AW'(1);
                        if (dir) begin
                            state       <= S_FETCH;
                            dma_rd_addr <= count + AW'(1);
                        end else begin
                            state <= S_SEND;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase

            // The in-flight byte always completes; abort takes effect at its STORE.
            if (busy && reg_wr && sram_a == 3'd0 && !sram_d_in[6]) abort <= 1'b1;
            if (reg_wr && sram_a == 3'd3) crc <= 16'h0000;
        end
    end

    always_comb begin
        sram_d_out = 8'h00;
        case (sram_a)
            3'd0:    sram_d_out = {avail, busy, dir, bits};
            3'd1:    sram_d_out = latch;
            3'd2:    sram_d_out = divider;
            3'd3:    sram_d_out = crc[7:0];
            3'd4:    sram_d_out = crc[15:8];
            3'd5:    sram_d_out = count_ext[7:0];
            3'd6:    sram_d_out = {4'b0000, count_ext[11:8]};
            default: sram_d_out = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_sdcard_dma_engine.sv
// Bench for sdcard_dma_engine: register table, manual SPI bytes, random block DMA
// against a card/RAM model, abort, reset mid-block, and a one-byte block instance.

module tb_sdcard_dma_engine;
    localparam int BL = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] sram_a;
    logic [7:0] sram_d_in;
    logic       sram_oe, sram_we, cs0, cs1, miso, sel;
    logic [7:0] dma_rd_data;

    logic       sclk0, mosi0, wait0, strobe0, done0;
    logic [7:0] dout0, wdata0;
    logic [3:0] waddr0, raddr0;
    logic       sclk1, mosi1, wait1, strobe1, done1;
    logic [7:0] dout1, wdata1;
    logic [0:0] waddr1, raddr1;

    always #5 clk = ~clk;

    sdcard_dma_engine #(.BLOCK_LEN(BL), .AW(4)) u_dut (
        .clk(clk), .rst(rst), .sclk(sclk0), .mosi(mosi0), .miso(miso),
        .sram_a(sram_a), .sram_d_in(sram_d_in), .sram_d_out(dout0),
        .sram_cs(cs0), .sram_oe(sram_oe), .sram_we(sram_we), .sram_wait(wait0),
        .dma_wr_data(wdata0), .dma_wr_addr(waddr0), .dma_wr_strobe(strobe0),
        .dma_rd_addr(raddr0), .dma_rd_data(dma_rd_data), .dma_done(done0)
    );

    sdcard_dma_engine #(.BLOCK_LEN(1), .AW(1)) u_one (
        .clk(clk), .rst(rst), .sclk(sclk1), .mosi(mosi1), .miso(miso),
        .sram_a(sram_a), .sram_d_in(sram_d_in), .sram_d_out(dout1),
        .sram_cs(cs1), .sram_oe(sram_oe), .sram_we(sram_we), .sram_wait(wait1),
        .dma_wr_data(wdata1), .dma_wr_addr(waddr1), .dma_wr_strobe(strobe1),
        .dma_rd_addr(raddr1), .dma_rd_data(dma_rd_data), .dma_done(done1)
    );

    logic       sclk_s, mosi_s, strobe_s, done_s;
    logic [7:0] dout_s, wdata_s, waddr_s, raddr_s;
    assign sclk_s   = sel ? sclk1   : sclk0;
    assign mosi_s   = sel ? mosi1   : mosi0;
    assign strobe_s = sel ? strobe1 : strobe0;
    assign done_s   = sel ? done1   : done0;
    assign dout_s   = sel ? dout1   : dout0;
    assign wdata_s  = sel ? wdata1  : wdata0;
    assign waddr_s  = sel ? {7'b0, waddr1} : {4'b0, waddr0};
    assign raddr_s  = sel ? {7'b0, raddr1} : {4'b0, raddr0};

    int total = 0;
    int bad   = 0;

    // RAM with one-cycle read latency
    logic [7:0] ram [BL];
    always @(posedge clk) dma_rd_data <= ram[raddr_s[3:0]];

    // Write-strobe and done monitor
    typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_t;
    wr_t wr_q[$];
    int  done_cnt = 0;
    always @(negedge clk) begin
        if (strobe_s) wr_q.push_back({waddr_s, wdata_s});
        if (done_s) done_cnt++;
    end

    // SD card model: mode 0, shifts miso on falling sclk, captures mosi on rising sclk
    logic [7:0] card_data [BL];
    logic [7:0] card_tx = 8'hFF;
    logic [7:0] card_rx = 8'h00;
    logic [7:0] mosi_q[$];
    logic       card_load = 1'b0;
    int card_idx = 0, tbits = 0, rbits = 0;
    assign miso = card_tx[7];
    always @(posedge sclk_s, negedge sclk_s, posedge card_load) begin
        if (card_load) begin
            card_idx = 0; tbits = 0; rbits = 0;
            card_tx  = card_data[0];
        end else if (sclk_s) begin
            card_rx = {card_rx[6:0], mosi_s};
            rbits++;
            if (rbits == 8) begin
                mosi_q.push_back(card_rx);
                rbits = 0;
            end
        end else begin
            tbits++;
            if (tbits == 8) begin
                tbits = 0;
                card_idx++;
                card_tx = (card_idx < BL) ? card_data[card_idx] : 8'hFF;
            end else begin
                card_tx = {card_tx[6:0], 1'b1};
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %04h expected %04h", name, act, exp);
        end
    endtask

    // Bit-serial CRC16-CCITT, init 0, MSB first
    function automatic logic [15:0] crc_model(input logic [7:0] b [BL], input int n);
        logic [15:0] c = 16'h0000;
        logic        fb;
        for (int i = 0; i < n; i++) begin
            for (int k = 7; k >= 0; k--) begin
                fb = c[15] ^ b[i][k];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        sram_a = a; sram_d_in = d; sram_we = 1'b1; cs0 = !sel; cs1 = sel;
        @(negedge clk);
        sram_we = 1'b0; cs0 = 1'b0; cs1 = 1'b0;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        sram_a = a;
        #1 d = dout_s;
    endtask

    task automatic load_card();
        card_load = 1'b1;
        #1 card_load = 1'b0;
    endtask

    int wr_base, mosi_base, done_base;
    logic [15:0] exp_crc;

    task automatic start_dma(input logic d);
        load_card();
        wr_base = wr_q.size(); mosi_base = mosi_q.size(); done_base = done_cnt;
        bus_wr(3'd0, {2'b01, d, 5'h01});
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_cnt == done_base && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("done_wait", 16'(done_cnt > done_base), 16'd1);
    endtask

    task automatic check_dma(input logic d, input int nb);
        logic [7:0] src [BL];
        logic [7:0] lo, hi, v;
        for (int i = 0; i < BL; i++) src[i] = d ? ram[i] : card_data[i];
        repeat (4) @(negedge clk);
        chk("done_pulses", 16'(done_cnt - done_base), 16'd1);
        chk("strobe_n", 16'(wr_q.size() - wr_base), d ? 16'd0 : 16'(nb));
        if (!d) begin
            for (int i = 0; i < nb && wr_base + i < wr_q.size(); i++) begin
                chk("strobe_addr", 16'(wr_q[wr_base + i].a), 16'(i));
                chk("strobe_data", 16'(wr_q[wr_base + i].d), 16'(src[i]));
            end
        end
        chk("mosi_n", 16'(mosi_q.size() - mosi_base), 16'(nb));
        for (int i = 0; i < nb && mosi_base + i < mosi_q.size(); i++)
            chk("mosi_byte", 16'(mosi_q[mosi_base + i]), d ? 16'(src[i]) : 16'h00FF);
        exp_crc = crc_model(src, nb);
        bus_rd(3'd3, lo);
        bus_rd(3'd4, hi);
        chk("crc", {hi, lo}, exp_crc);
        bus_rd(3'd5, v);
        chk("count_lo", 16'(v), 16'(nb - 1));
        bus_rd(3'd6, v);
        chk("count_hi", 16'(v), 16'd0);
        bus_rd(3'd0, v);
        chk("busy_dir", 16'(v[6:5]), {15'd0, d});
    endtask

    task automatic manual_byte(input logic [7:0] tx, input logic [7:0] rx, input logic [15:0] crc_exp);
        logic [7:0] v;
        int k;
        card_data[0] = rx;
        load_card();
        mosi_base = mosi_q.size();
        bus_wr(3'd1, tx);
        v = 8'h00;
        k = 0;
        while (!v[7] && k < 400) begin
            bus_rd(3'd0, v);
            k++;
        end
        chk("man_avail", 16'(v[7]), 16'd1);
        bus_rd(3'd1, v);
        chk("man_latch", 16'(v), 16'(rx));
        chk("man_mosi", (mosi_q.size() > mosi_base) ? 16'(mosi_q[mosi_base]) : 16'hFFFF, 16'(tx));
        bus_rd(3'd3, v);
        chk("man_crc_lo", 16'(v), 16'(crc_exp[7:0]));
        bus_rd(3'd4, v);
        chk("man_crc_hi", 16'(v), 16'(crc_exp[15:8]));
    endtask

    typedef struct {
        logic       wr;
        logic [2:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    initial begin
        vec_t       vecs[$];
        logic [7:0] v;
        logic       dr;
        int         k, wb, db;

        rst = 1'b1; sram_a = 3'd0; sram_d_in = 8'h00; sram_oe = 1'b0; sram_we = 1'b0;
        cs0 = 1'b0; cs1 = 1'b0; sel = 1'b0;
        for (int i = 0; i < BL; i++) begin card_data[i] = 8'hFF; ram[i] = 8'h00; end
        load_card();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        vecs = '{
            '{1'b0, 3'd0, 8'h00, 8'h00}, '{1'b0, 3'd1, 8'h00, 8'h00},
            '{1'b0, 3'd2, 8'h00, 8'h00}, '{1'b0, 3'd3, 8'h00, 8'h00},
            '{1'b0, 3'd4, 8'h00, 8'h00}, '{1'b0, 3'd5, 8'h00, 8'h00},
            '{1'b0, 3'd6, 8'h00, 8'h00}, '{1'b0, 3'd7, 8'h00, 8'h00},
            '{1'b1, 3'd2, 8'h5A, 8'h00}, '{1'b0, 3'd2, 8'h00, 8'h5A},
            '{1'b1, 3'd0, 8'h9F, 8'h00}, '{1'b0, 3'd0, 8'h00, 8'h9F},
            '{1'b1, 3'd0, 8'h03, 8'h00}, '{1'b0, 3'd0, 8'h00, 8'h03},
            '{1'b1, 3'd7, 8'hFF, 8'h00}, '{1'b0, 3'd7, 8'h00, 8'h00},
            '{1'b1, 3'd2, 8'h00, 8'h00}, '{1'b0, 3'd2, 8'h00, 8'h00}
        };
        foreach (vecs[i]) begin
            if (vecs[i].wr) bus_wr(vecs[i].a, vecs[i].d);
            else begin
                bus_rd(vecs[i].a, v);
                chk($sformatf("reg%0d_vec%0d", vecs[i].a, i), 16'(v), 16'(vecs[i].exp));
            end
        end

        // Manual byte at divider 2, bits 8
        bus_wr(3'd2, 8'h02);
        bus_wr(3'd0, 8'h08);
        manual_byte(8'hA5, 8'h3C, 16'h0000);
        bus_wr(3'd2, 8'h00);

        // Directed read block: card supplies "1234..."
        for (int i = 0; i < BL; i++) card_data[i] = 8'h31 + 8'(i);
        start_dma(1'b0);
        wait_done(3000);
        check_dma(1'b0, BL);

        // Directed write block: RAM holds 00,01,02,...
        for (int i = 0; i < BL; i++) ram[i] = 8'(i);
        start_dma(1'b1);
        wait_done(3000);
        check_dma(1'b1, BL);

        // Random blocks; odd iterations also poke reg1 mid-block, which must be ignored
        for (int it = 0; it < 6; it++) begin
            dr = 1'($urandom_range(0, 1));
            for (int i = 0; i < BL; i++) begin
                card_data[i] = 8'($urandom);
                ram[i]       = 8'($urandom);
            end
            start_dma(dr);
            if (it % 2 == 1) begin
                repeat (30) @(negedge clk);
                bus_wr(3'd1, 8'h55);
            end
            wait_done(3000);
            check_dma(dr, BL);
        end

        // Manual byte leaves the block CRC alone; a reg3 write clears it
        manual_byte(8'h81, 8'hC3, exp_crc);
        bus_wr(3'd3, 8'h77);
        bus_rd(3'd3, v);
        chk("crc_clr_lo", 16'(v), 16'd0);
        bus_rd(3'd4, v);
        chk("crc_clr_hi", 16'(v), 16'd0);

        // Abort requested while byte 10 is in flight
        for (int i = 0; i < BL; i++) card_data[i] = 8'($urandom);
        start_dma(1'b0);
        k = 0;
        while (wr_q.size() - wr_base < 10 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("abort_reach10", 16'(wr_q.size() - wr_base), 16'd10);
        bus_wr(3'd0, 8'h00);
        wait_done(3000);
        check_dma(1'b0, 11);

        // Reset in the middle of a block
        bus_wr(3'd2, 8'h01);
        for (int i = 0; i < BL; i++) card_data[i] = 8'($urandom);
        start_dma(1'b0);
        k = 0;
        while (wr_q.size() - wr_base < 5 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("rst_reach5", 16'(wr_q.size() - wr_base), 16'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wb = wr_q.size();
        db = done_cnt;
        repeat (400) @(negedge clk);
        chk("rst_no_strobe", 16'(wr_q.size() - wb), 16'd0);
        chk("rst_no_done", 16'(done_cnt - done_base), 16'd0);
        chk("rst_no_done_after", 16'(done_cnt - db), 16'd0);
        for (int a = 0; a < 7; a++) begin
            bus_rd(3'(a), v);
            chk($sformatf("rst_reg%0d", a), 16'(v), 16'd0);
        end

        // One-byte block instance: read then write
        sel = 1'b1;
        card_data[0] = 8'($urandom);
        start_dma(1'b0);
        wait_done(1000);
        check_dma(1'b0, 1);
        ram[0] = 8'($urandom);
        start_dma(1'b1);
        wait_done(1000);
        check_dma(1'b1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
